// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: result-source ids, load sizes, width defaults.
package mips_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  localparam int RES_ALU  = 0;
  localparam int RES_MEM  = 1;
  localparam int RES_LINK = 2;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  // Select width for n sources, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/load_extender.sv
// Sub-word load lane extraction and sign/zero extension to the datapath width.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_extender
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [DATA_W-1:0] byte_shift;
  logic [DATA_W-1:0] half_shift;

  // Shifting instead of indexing keeps narrow datapaths safe: lanes past the top read as zero.
  always_comb begin
    byte_shift = raw >> {offset, 3'b000};
    half_shift = raw >> {offset[1], 4'b0000};
    byte_lane  = byte_shift[7:0];
    half_lane  = half_shift[15:0];
  end

  always_comb begin
    ext = raw;
    case (size)
      LD_BYTE: ext = {{(DATA_W-8){sign_ext & byte_lane[7]}}, byte_lane};
      LD_HALF: ext = {{(DATA_W-16){sign_ext & half_lane[15]}}, half_lane};
      LD_WORD: ext = raw;
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/writeback_stage_pipe.sv
// MEM/WB register, N-way result select, register-file write gating, retire counter.
// Latency: one cycle from M_* inputs to W_* outputs.
// Backpressure: W_stall holds all state; W_flush (higher priority) loads a bubble.
module writeback_stage_pipe
  import mips_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_SRC    = 3,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  W_stall,
  input  logic                  W_flush,
  input  logic                  M_valid_M,
  input  logic [DATA_W-1:0]     M_ALU_out_M,
  input  logic [DATA_W-1:0]     M_read_data_M,
  input  logic [DATA_W-1:0]     M_link_addr_M,
  input  logic [SEL_W-1:0]      M_resultSel_M,
  input  logic [1:0]            M_loadSize_M,
  input  logic                  M_loadSigned_M,
  input  logic                  M_regWrite_M,
  input  logic [REG_ADDR_W-1:0] M_writeReg_M,
  output logic [DATA_W-1:0]     W_Result_W,
  output logic [REG_ADDR_W-1:0] W_writeReg_W,
  output logic                  W_regWrite_W,
  output logic                  W_valid_W,
  output logic                  W_misaligned_W,
  output logic [CNT_W-1:0]      W_retired_W
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rdata;
    logic [DATA_W-1:0]     link;
    logic [SEL_W-1:0]      sel;
    logic [1:0]            size;
    logic                  sign_ext;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_reg;
  } wb_fields_t;

  wb_fields_t        wb_d;
  wb_fields_t        wb_q;
  logic [CNT_W-1:0]  retired_q;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] result;

  always_comb begin
    wb_d           = '0;
    wb_d.valid     = M_valid_M;
    wb_d.alu       = M_ALU_out_M;
    wb_d.rdata     = M_read_data_M;
    wb_d.link      = M_link_addr_M;
    wb_d.sel       = M_resultSel_M;
    wb_d.size      = M_loadSize_M;
    wb_d.sign_ext  = M_loadSigned_M;
    wb_d.reg_write = M_regWrite_M;
    wb_d.write_reg = M_writeReg_M;
  end

  // Priority: reset, then flush (even when stalled), then stall, then load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q      <= '0;
      retired_q <= '0;
    end else if (W_flush) begin
      wb_q      <= '0;
    end else if (!W_stall) begin
      wb_q <= wb_d;
      if (M_valid_M) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // The byte offset travels in the captured ALU address.
  load_extender #(
    .DATA_W (DATA_W)
  ) u_load_extender (
    .raw      (wb_q.rdata),
    .offset   (wb_q.alu[1:0]),
    .size     (wb_q.size),
    .sign_ext (wb_q.sign_ext),
    .ext      (load_ext)
  );

  always_comb begin
    result = '0;
    if (int'(wb_q.sel) < NUM_SRC) begin
      case (int'(wb_q.sel))
        RES_ALU:  result = wb_q.alu;
        RES_MEM:  result = load_ext;
        RES_LINK: result = wb_q.link;
        default:  result = '0;
      endcase
    end
  end

  // A write to $0 is dropped, but the result bus still carries the value.
  always_comb begin
    W_Result_W     = result;
    W_writeReg_W   = wb_q.write_reg;
    W_valid_W      = wb_q.valid;
    W_regWrite_W   = wb_q.valid & wb_q.reg_write & (wb_q.write_reg != '0);
    W_misaligned_W = wb_q.valid & (wb_q.size == LD_HALF) & wb_q.alu[0];
    W_retired_W    = retired_q;
  end

endmodule

// File: tb/tb_writeback_stage_pipe.sv
// Directed bench for writeback_stage_pipe with a spec-level model and per-cycle compare.
module tb_writeback_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        W_stall, W_flush;
  logic        M_valid_M;
  logic [31:0] M_ALU_out_M, M_read_data_M, M_link_addr_M;
  logic [1:0]  M_resultSel_M, M_loadSize_M;
  logic        M_loadSigned_M, M_regWrite_M;
  logic [4:0]  M_writeReg_M;

  logic [31:0] res_a, res_b;
  logic [4:0]  wr_a, wr_b;
  logic        rw_a, rw_b, vld_a, vld_b, mis_a, mis_b;
  logic [31:0] ret_a;
  logic [3:0]  ret_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  writeback_stage_pipe #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .W_stall(W_stall), .W_flush(W_flush),
    .M_valid_M(M_valid_M), .M_ALU_out_M(M_ALU_out_M), .M_read_data_M(M_read_data_M),
    .M_link_addr_M(M_link_addr_M), .M_resultSel_M(M_resultSel_M), .M_loadSize_M(M_loadSize_M),
    .M_loadSigned_M(M_loadSigned_M), .M_regWrite_M(M_regWrite_M), .M_writeReg_M(M_writeReg_M),
    .W_Result_W(res_a), .W_writeReg_W(wr_a), .W_regWrite_W(rw_a), .W_valid_W(vld_a),
    .W_misaligned_W(mis_a), .W_retired_W(ret_a)
  );

  writeback_stage_pipe #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .W_stall(W_stall), .W_flush(W_flush),
    .M_valid_M(M_valid_M), .M_ALU_out_M(M_ALU_out_M), .M_read_data_M(M_read_data_M),
    .M_link_addr_M(M_link_addr_M), .M_resultSel_M(M_resultSel_M), .M_loadSize_M(M_loadSize_M),
    .M_loadSigned_M(M_loadSigned_M), .M_regWrite_M(M_regWrite_M), .M_writeReg_M(M_writeReg_M),
    .W_Result_W(res_b), .W_writeReg_W(wr_b), .W_regWrite_W(rw_b), .W_valid_W(vld_b),
    .W_misaligned_W(mis_b), .W_retired_W(ret_b)
  );

  // Model state: the last accepted instruction and a plain retired count.
  bit          m_valid, m_sgn, m_rw;
  logic [31:0] m_alu, m_rd, m_link;
  int          m_sel, m_size, m_wr;
  longint      m_cnt;

  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      m_valid = 0; m_alu = 0; m_rd = 0; m_link = 0; m_sel = 0; m_size = 0;
      m_sgn = 0; m_rw = 0; m_wr = 0; m_cnt = 0;
    end else if (W_flush) begin
      m_valid = 0; m_alu = 0; m_rd = 0; m_link = 0; m_sel = 0; m_size = 0;
      m_sgn = 0; m_rw = 0; m_wr = 0;
    end else if (!W_stall) begin
      m_valid = M_valid_M; m_alu = M_ALU_out_M; m_rd = M_read_data_M;
      m_link = M_link_addr_M; m_sel = int'(M_resultSel_M); m_size = int'(M_loadSize_M);
      m_sgn = M_loadSigned_M; m_rw = M_regWrite_M; m_wr = int'(M_writeReg_M);
      if (M_valid_M) m_cnt = m_cnt + 1;
    end
  end

  function automatic logic [31:0] exp_load();
    logic [31:0] v;
    int off;
    off = int'(m_alu % 4);
    if (m_size == 0) begin
      v = (m_rd >> (8 * off)) % 256;
      if (m_sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (m_size == 1) begin
      v = (m_rd >> (16 * (off / 2))) % 65536;
      if (m_sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = m_rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_result();
    if (m_sel == 0) return m_alu;
    if (m_sel == 1) return exp_load();
    if (m_sel == 2) return m_link;
    return 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] er;
      logic        erw, emis;
      er   = exp_result();
      erw  = m_valid && m_rw && (m_wr != 0);
      emis = m_valid && (m_size == 1) && (m_alu % 2 == 1);
      chk("result",     res_a, er);
      chk("write_reg",  32'(wr_a), 32'(m_wr));
      chk("reg_write",  32'(rw_a), 32'(erw));
      chk("valid",      32'(vld_a), 32'(m_valid));
      chk("misaligned", 32'(mis_a), 32'(emis));
      chk("retired",    ret_a, 32'(m_cnt % 64'h1_0000_0000));
      chk("w4_result",  res_b, er);
      chk("w4_regwr",   32'(rw_b), 32'(erw));
      chk("w4_valid",   32'(vld_b), 32'(m_valid));
      chk("w4_retired", 32'(ret_b), 32'(m_cnt % 16));
      chk("w4_wreg_mis", 32'({wr_b, mis_b}), 32'({m_wr[4:0], emis}));
    end
  end

  task automatic drive(input bit v, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] link, input logic [1:0] sel, input logic [1:0] size,
                       input bit sgn, input bit rw, input logic [4:0] wr);
    M_valid_M = v; M_ALU_out_M = alu; M_read_data_M = rd; M_link_addr_M = link;
    M_resultSel_M = sel; M_loadSize_M = size; M_loadSigned_M = sgn;
    M_regWrite_M = rw; M_writeReg_M = wr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    W_stall = 0; W_flush = 0; rst = 0;
    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, $urandom, $urandom, 2'($urandom), 2'($urandom), 1'b1, 1'b1, 5'($urandom));
      chk_en = 1'b1;
    end
    chk("rst_result", res_a, 32'h0);
    chk("rst_retired", ret_a, 32'h0);
    chk("rst_valid", 32'(vld_a), 32'h0);
    rst = 1'b1;

    // Sub-word loads from 80F1_7F82.
    drive(1, 32'h0, 32'h80F1_7F82, 0, 2'd1, 2'b00, 1, 1, 5'd3);
    chk("lb_off0_s", res_a, 32'hFFFF_FF82);
    drive(1, 32'h1, 32'h80F1_7F82, 0, 2'd1, 2'b00, 0, 1, 5'd3);
    chk("lbu_off1", res_a, 32'h0000_007F);
    drive(1, 32'h2, 32'h80F1_7F82, 0, 2'd1, 2'b01, 1, 1, 5'd3);
    chk("lh_off2_s", res_a, 32'hFFFF_80F1);
    chk("lh_off2_mis", 32'(mis_a), 32'h0);
    drive(1, 32'h1, 32'h80F1_7F82, 0, 2'd1, 2'b01, 0, 1, 5'd3);
    chk("lhu_off1", res_a, 32'h0000_7F82);
    chk("lhu_off1_mis", 32'(mis_a), 32'h1);
    drive(1, 32'h3, 32'h80F1_7F82, 0, 2'd1, 2'b11, 1, 1, 5'd3);
    chk("lw_size3", res_a, 32'h80F1_7F82);

    // Result select.
    drive(1, 32'h1234, 32'hDEAD_BEEF, 32'h0040_0008, 2'd0, 2'b10, 0, 1, 5'd4);
    chk("sel_alu", res_a, 32'h0000_1234);
    drive(1, 32'h1234, 32'hDEAD_BEEF, 32'h0040_0008, 2'd2, 2'b10, 0, 1, 5'd4);
    chk("sel_link", res_a, 32'h0040_0008);
    drive(1, 32'h1234, 32'hDEAD_BEEF, 32'h0040_0008, 2'd3, 2'b10, 0, 1, 5'd4);
    chk("sel_oob", res_a, 32'h0);

    // Write gating on $0.
    drive(1, 32'h55, 0, 0, 2'd0, 2'b10, 0, 1, 5'd0);
    chk("wr_r0", 32'(rw_a), 32'h0);
    chk("wr_r0_result", res_a, 32'h55);
    drive(1, 32'h55, 0, 0, 2'd0, 2'b10, 0, 1, 5'd5);
    chk("wr_r5", 32'(rw_a), 32'h1);
    drive(0, 32'h66, 0, 0, 2'd0, 2'b10, 0, 1, 5'd5);
    chk("bubble_wr", 32'(rw_a), 32'h0);

    // Stall and flush across ten valid instructions.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 32'h100 + i, 0, 0, 2'd0, 2'b10, 0, 1, 5'd7);
    chk("pre_stall_ret", ret_a, 32'd4);
    W_stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h200 + i, 0, 0, 2'd0, 2'b10, 0, 1, 5'd9);
      chk("stall_result", res_a, 32'h103);
      chk("stall_ret", ret_a, 32'd4);
    end
    W_flush = 1;
    drive(1, 32'h300, 0, 0, 2'd0, 2'b10, 0, 1, 5'd9);
    chk("flush_valid", 32'(vld_a), 32'h0);
    chk("flush_ret", ret_a, 32'd4);
    W_flush = 0; W_stall = 0;
    for (int i = 4; i < 10; i++) drive(1, 32'h100 + i, 0, 0, 2'd0, 2'b10, 0, 1, 5'd7);
    chk("seq_ret", ret_a, 32'd10);
    chk("seq_result", res_a, 32'h109);

    // Four-bit counter wrap, then reset while stalled.
    do_reset();
    for (int i = 0; i < 17; i++) drive(1, 32'(i), 0, 0, 2'd0, 2'b10, 0, 1, 5'd1);
    chk("wrap_w4", 32'(ret_b), 32'd1);
    chk("wrap_w32", ret_a, 32'd17);
    rst = 0; W_stall = 1;
    drive(1, 32'h77, 0, 0, 2'd0, 2'b10, 0, 1, 5'd1);
    chk("rst_stall_w4", 32'(ret_b), 32'd0);
    chk("rst_stall_w32", ret_a, 32'd0);
    rst = 1; W_stall = 0;
    drive(1, 32'h78, 0, 0, 2'd0, 2'b10, 0, 1, 5'd1);
    chk("post_rst_ret", ret_a, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
